// File: rtl/taillight_pkg.sv
// Shared types for the taillight sequence monitor: FSM states, error codes,
// lamp pattern constants and the pattern classes produced by the classifier.
package taillight_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_START  = 2'd1,
        ERR_BAD_STEP   = 2'd2,
        ERR_BOTH_SIDES = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        CLS_OFF, CLS_L1, CLS_L2, CLS_L3, CLS_R1, CLS_R2, CLS_R3, CLS_BOTH, CLS_ILLEGAL
    } lamp_class_t;

    // Lamp vector order is {la, lb, lc, ra, rb, rc}.
    localparam logic [5:0] PAT_OFF = 6'b000_000;
    localparam logic [5:0] PAT_L1  = 6'b100_000;
    localparam logic [5:0] PAT_L2  = 6'b110_000;
    localparam logic [5:0] PAT_L3  = 6'b111_000;
    localparam logic [5:0] PAT_R1  = 6'b000_100;
    localparam logic [5:0] PAT_R2  = 6'b000_110;
    localparam logic [5:0] PAT_R3  = 6'b000_111;

    // Pattern that keeps a lit state where it is.
    function automatic lamp_class_t hold_class(state_t s);
        case (s)
            ST_L1:   return CLS_L1;
            ST_L2:   return CLS_L2;
            ST_L3:   return CLS_L3;
            ST_R1:   return CLS_R1;
            ST_R2:   return CLS_R2;
            ST_R3:   return CLS_R3;
            default: return CLS_ILLEGAL;
        endcase
    endfunction

    // Pattern that legally ends a lit state once its hold time has elapsed.
    function automatic lamp_class_t advance_class(state_t s);
        case (s)
            ST_L1:        return CLS_L2;
            ST_L2:        return CLS_L3;
            ST_R1:        return CLS_R2;
            ST_R2:        return CLS_R3;
            ST_L3, ST_R3: return CLS_OFF;
            default:      return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic state_t advance_state(state_t s);
        case (s)
            ST_L1:   return ST_L2;
            ST_L2:   return ST_L3;
            ST_R1:   return ST_R2;
            ST_R2:   return ST_R3;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/taillight_classify.sv
// Combinational classifier: maps the six lamp outputs onto one pattern class.
module taillight_classify
    import taillight_pkg::*;
(
    input  logic        la,
    input  logic        lb,
    input  logic        lc,
    input  logic        ra,
    input  logic        rb,
    input  logic        rc,
    output lamp_class_t cls
);

    logic [5:0] pat;
    assign pat = {la, lb, lc, ra, rb, rc};

    always_comb begin
        // NOTE: default first so every path assigns cls and no latch is inferred.
        cls = CLS_ILLEGAL;
        if ((|pat[5:3]) && (|pat[2:0])) begin
            cls = CLS_BOTH;
        end else begin
            case (pat)
                PAT_OFF: cls = CLS_OFF;
                PAT_L1:  cls = CLS_L1;
                PAT_L2:  cls = CLS_L2;
                PAT_L3:  cls = CLS_L3;
                PAT_R1:  cls = CLS_R1;
                PAT_R2:  cls = CLS_R2;
                PAT_R3:  cls = CLS_R3;
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/taillight_monitor.sv
// Protocol monitor for a three-lamp turn-signal sequencer: tracks legal left and
// right sequences, counts completions and latches the first protocol violation.
module taillight_monitor
    import taillight_pkg::*;
#(
    parameter int STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       la,
    input  logic       lb,
    input  logic       lc,
    input  logic       ra,
    input  logic       rb,
    input  logic       rc,
    input  logic       clear,
    output logic       left_active,
    output logic       right_active,
    output logic       left_done,
    output logic       right_done,
    output logic [7:0] left_cnt,
    output logic [7:0] right_cnt,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [3:0] STEP = 4'(STEP_CYCLES);

    state_t      state, next_state;
    logic [3:0]  hold, next_hold;
    err_code_t   code_q, next_code;
    logic        left_fire, right_fire;
    lamp_class_t cls;

    taillight_classify u_classify (
        .la (la), .lb (lb), .lc (lc),
        .ra (ra), .rb (rb), .rc (rc),
        .cls(cls)
    );

    always_comb begin
        next_state = state;
        next_hold  = hold;
        next_code  = code_q;
        left_fire  = 1'b0;
        right_fire = 1'b0;
        if (clear) begin
            next_state = ST_IDLE;
            next_hold  = '0;
            next_code  = ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_hold = '0;
                    case (cls)
                        CLS_OFF:  next_state = ST_IDLE;
                        CLS_L1:   begin next_state = ST_L1; next_hold = 4'd1; end
                        CLS_R1:   begin next_state = ST_R1; next_hold = 4'd1; end
                        CLS_BOTH: begin next_state = ST_ERR; next_code = ERR_BOTH_SIDES; end
                        default:  begin next_state = ST_ERR; next_code = ERR_BAD_START; end
                    endcase
                end
                ST_ERR: next_state = ST_ERR;
                default: begin
                    // Hold counts cycles already spent in this lit state, entry cycle included.
                    if (cls == CLS_BOTH) begin
                        next_state = ST_ERR;
                        next_hold  = '0;
                        next_code  = ERR_BOTH_SIDES;
                    end else if (cls == hold_class(state) && hold < STEP) begin
                        next_hold = hold + 4'd1;
                    end else if (cls == advance_class(state) && hold == STEP) begin
                        next_state = advance_state(state);
                        if (advance_state(state) == ST_IDLE) begin
                            next_hold  = '0;
                            left_fire  = (state == ST_L3);
                            right_fire = (state == ST_R3);
                        end else begin
                            next_hold = 4'd1;
                        end
                    end else begin
                        next_state = ST_ERR;
                        next_hold  = '0;
                        next_code  = ERR_BAD_STEP;
                    end
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments; all decisions live in the comb block above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hold         <= '0;
            code_q       <= ERR_NONE;
            error        <= 1'b0;
            left_active  <= 1'b0;
            right_active <= 1'b0;
            left_done    <= 1'b0;
            right_done   <= 1'b0;
            left_cnt     <= '0;
            right_cnt    <= '0;
        end else begin
            state        <= next_state;
            hold         <= next_hold;
            code_q       <= next_code;
            error        <= (next_state == ST_ERR);
            left_active  <= next_state inside {ST_L1, ST_L2, ST_L3};
            right_active <= next_state inside {ST_R1, ST_R2, ST_R3};
            left_done    <= left_fire;
            right_done   <= right_fire;
            if (left_fire && left_cnt != 8'hFF)
                left_cnt <= left_cnt + 8'd1;
            if (right_fire && right_cnt != 8'hFF)
                right_cnt <= right_cnt + 8'd1;
        end
    end

    assign err_code = code_q;

endmodule

// File: tb/tb_taillight_monitor.sv
// Scoreboard bench: two monitors (STEP_CYCLES 1 and 2) share one lamp stream;
// a sequence-prefix reference model predicts every registered output per cycle.
module tb_taillight_monitor;

    typedef struct packed {
        logic       la;
        logic       ra;
        logic       ld;
        logic       rd;
        logic [7:0] lc;
        logic [7:0] rc;
        logic       er;
        logic [1:0] code;
    } obs_t;

    localparam logic [5:0] OFF = 6'b000_000;
    localparam logic [5:0] L1  = 6'b100_000;
    localparam logic [5:0] L2  = 6'b110_000;
    localparam logic [5:0] L3  = 6'b111_000;
    localparam logic [5:0] R1  = 6'b000_100;
    localparam logic [5:0] R2  = 6'b000_110;
    localparam logic [5:0] R3  = 6'b000_111;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [5:0] lamps;

    logic       d1_left_active, d1_right_active, d1_left_done, d1_right_done, d1_error;
    logic [7:0] d1_left_cnt, d1_right_cnt;
    logic [1:0] d1_err_code;
    logic       d2_left_active, d2_right_active, d2_left_done, d2_right_done, d2_error;
    logic [7:0] d2_left_cnt, d2_right_cnt;
    logic [1:0] d2_err_code;

    obs_t act1, act2;
    assign act1 = {d1_left_active, d1_right_active, d1_left_done, d1_right_done,
                   d1_left_cnt, d1_right_cnt, d1_error, d1_err_code};
    assign act2 = {d2_left_active, d2_right_active, d2_left_done, d2_right_done,
                   d2_left_cnt, d2_right_cnt, d2_error, d2_err_code};

    taillight_monitor #(.STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .la(lamps[5]), .lb(lamps[4]), .lc(lamps[3]),
        .ra(lamps[2]), .rb(lamps[1]), .rc(lamps[0]),
        .clear(clear),
        .left_active(d1_left_active), .right_active(d1_right_active),
        .left_done(d1_left_done), .right_done(d1_right_done),
        .left_cnt(d1_left_cnt), .right_cnt(d1_right_cnt),
        .error(d1_error), .err_code(d1_err_code)
    );

    taillight_monitor #(.STEP_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .la(lamps[5]), .lb(lamps[4]), .lc(lamps[3]),
        .ra(lamps[2]), .rb(lamps[1]), .rc(lamps[0]),
        .clear(clear),
        .left_active(d2_left_active), .right_active(d2_right_active),
        .left_done(d2_left_done), .right_done(d2_right_done),
        .left_cnt(d2_left_cnt), .right_cnt(d2_right_cnt),
        .error(d2_error), .err_code(d2_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a sequence is the golden list of 3*S lit samples plus one OFF;
    // the model only tracks how far into that list the observed samples have matched.
    int   steps[2] = '{1, 2};
    int   side[2];
    int   pos[2];
    int   err[2];
    int   lcnt[2];
    int   rcnt[2];
    obs_t q0[$];
    obs_t q1[$];

    function automatic logic [5:0] golden(int sd, int s, int idx);
        int         k;
        logic [2:0] bars;
        k = idx / s;
        if (k >= 3) return 6'b0;
        bars = (k == 0) ? 3'b100 : (k == 1) ? 3'b110 : 3'b111;
        return (sd == 1) ? {bars, 3'b000} : {3'b000, bars};
    endfunction

    task automatic model_step(input int d, input logic [5:0] p, input logic rst, input logic clr);
        obs_t e;
        logic ld, rd;
        ld = 1'b0;
        rd = 1'b0;
        if (rst) begin
            side[d] = 0; pos[d] = 0; err[d] = 0; lcnt[d] = 0; rcnt[d] = 0;
        end else if (clr) begin
            side[d] = 0; pos[d] = 0; err[d] = 0;
        end else if (err[d] == 0) begin
            if ((|p[5:3]) && (|p[2:0])) begin
                err[d] = 3; side[d] = 0; pos[d] = 0;
            end else if (pos[d] == 0) begin
                if (p == golden(1, steps[d], 0)) begin
                    side[d] = 1; pos[d] = 1;
                end else if (p == golden(2, steps[d], 0)) begin
                    side[d] = 2; pos[d] = 1;
                end else if (p != 6'b0) begin
                    err[d] = 1;
                end
            end else if (p == golden(side[d], steps[d], pos[d])) begin
                pos[d]++;
                if (pos[d] == 3 * steps[d] + 1) begin
                    if (side[d] == 1) begin
                        ld = 1'b1;
                        if (lcnt[d] < 255) lcnt[d]++;
                    end else begin
                        rd = 1'b1;
                        if (rcnt[d] < 255) rcnt[d]++;
                    end
                    side[d] = 0; pos[d] = 0;
                end
            end else begin
                err[d] = 2; side[d] = 0; pos[d] = 0;
            end
        end
        e.la   = (side[d] == 1);
        e.ra   = (side[d] == 2);
        e.ld   = ld;
        e.rd   = rd;
        e.lc   = 8'(lcnt[d]);
        e.rc   = 8'(rcnt[d]);
        e.er   = (err[d] != 0);
        e.code = 2'(err[d]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Drive one sample, predict both monitors, then move to the next falling edge.
    task automatic cycle(input logic [5:0] p, input logic rst = 1'b0, input logic clr = 1'b0);
        lamps = p;
        reset = rst;
        clear = clr;
        model_step(0, p, rst, clr);
        model_step(1, p, rst, clr);
        @(negedge clk);
    endtask

    int   mcyc = 0;
    logic stim_done = 1'b0;

    always begin
        obs_t e;
        @(posedge clk);
        #1;
        if (!stim_done) begin
            if (q0.size() == 0) check($sformatf("sb1_empty_c%0d", mcyc), 32'd0, 32'd1);
            else begin
                e = q0.pop_front();
                check($sformatf("sb_dut1_c%0d", mcyc), 32'(act1), 32'(e));
            end
            if (q1.size() == 0) check($sformatf("sb2_empty_c%0d", mcyc), 32'd0, 32'd1);
            else begin
                e = q1.pop_front();
                check($sformatf("sb_dut2_c%0d", mcyc), 32'(act2), 32'(e));
            end
        end
        mcyc++;
    end

    initial begin
        int         s, sd, len;
        logic [5:0] p;
        lamps = OFF;
        reset = 1'b1;
        clear = 1'b0;

        cycle(OFF, 1'b1);
        cycle(OFF, 1'b1);
        check("reset_dut1", 32'(act1), 32'd0);
        check("reset_dut2", 32'(act2), 32'd0);

        // Single-step left sequence on the STEP_CYCLES=1 monitor.
        cycle(OFF); cycle(L1); cycle(L2); cycle(L3); cycle(OFF);
        check("s1_left_done", 32'(d1_left_done), 32'd1);
        check("s1_left_cnt", 32'(d1_left_cnt), 32'd1);
        check("s1_error", 32'(d1_error), 32'd0);
        cycle(OFF);
        check("s1_done_width", 32'(d1_left_done), 32'd0);
        cycle(OFF, 1'b0, 1'b1);

        // Two-cycle right sequence, then one with R2 held too briefly.
        cycle(R1); cycle(R1); cycle(R2); cycle(R2); cycle(R3); cycle(R3); cycle(OFF);
        check("s2_right_done", 32'(d2_right_done), 32'd1);
        check("s2_right_cnt", 32'(d2_right_cnt), 32'd1);
        cycle(OFF);
        check("s2_done_width", 32'(d2_right_done), 32'd0);
        cycle(R1); cycle(R1); cycle(R2); cycle(R3);
        check("s2_short_error", 32'(d2_error), 32'd1);
        check("s2_short_code", 32'(d2_err_code), 32'd2);
        cycle(OFF, 1'b0, 1'b1);

        // Both sides lit while in L2.
        cycle(L1); cycle(L2); cycle(6'b110_100);
        check("both_code", 32'(d1_err_code), 32'd3);
        check("both_left_active", 32'(d1_left_active), 32'd0);
        check("both_error", 32'(d1_error), 32'd1);
        for (int i = 0; i < 5; i++) cycle(6'($urandom));
        check("both_code_sticky", 32'(d1_err_code), 32'd3);
        cycle(OFF, 1'b0, 1'b1);

        // Illegal start from IDLE, then clear.
        cycle(6'b101_000);
        check("bad_start_code", 32'(d1_err_code), 32'd1);
        cycle(OFF, 1'b0, 1'b1);
        check("clear_error", 32'(d1_error), 32'd0);
        check("clear_keeps_cnt", 32'(d1_left_cnt), 32'd1);
        check("clear_keeps_rcnt", 32'(d2_right_cnt), 32'd1);

        // Reset in the middle of R2, then clear racing a violation.
        cycle(R1); cycle(R1); cycle(R2);
        check("mid_r2_active", 32'(d2_right_active), 32'd1);
        cycle(R2, 1'b1);
        check("mid_reset_dut2", 32'(act2), 32'd0);
        cycle(L1);
        cycle(6'b100_001, 1'b0, 1'b1);
        check("clear_wins_dut1", 32'(d1_error), 32'd0);
        check("clear_wins_dut2", 32'(d2_error), 32'd0);

        // Random sequences with occasional glitches, clears and resets.
        for (int n = 0; n < 80; n++) begin
            s   = int'($urandom_range(1, 2));
            sd  = int'($urandom_range(1, 2));
            len = 3 * s + 1;
            for (int i = 0; i < len; i++) begin
                p = golden(sd, s, i);
                if ($urandom_range(0, 14) == 0) p = 6'($urandom);
                cycle(p, $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
            end
            cycle(OFF, 1'b0, $urandom_range(0, 1) == 1);
        end

        // Saturation of the left counter.
        cycle(OFF, 1'b1);
        for (int n = 0; n < 260; n++) begin
            cycle(L1); cycle(L2); cycle(L3); cycle(OFF);
            check($sformatf("sat_done_%0d", n), 32'(d1_left_done), 32'd1);
        end
        check("sat_left_cnt", 32'(d1_left_cnt), 32'd255);
        cycle(OFF);

        stim_done = 1'b1;
        check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taillight_monitor.md
TAILLIGHT_MONITOR -- requirements
Module: taillight_monitor

Interface
REQ-001 Parameter STEP_CYCLES, default 1: cycles each lit lamp pattern is held by the lamp sequencer; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 la, lb, lc  input  1 each  left lamp outputs of the turn-signal sequencer.
REQ-005 ra, rb, rc  input  1 each  right lamp outputs of the turn-signal sequencer.
REQ-006 clear  input  1  synchronous error clear; returns monitor to IDLE.
REQ-007 left_active, right_active  output  1 each  monitor currently tracking a left/right sequence.
REQ-008 left_done, right_done  output  1 each  one-cycle pulse on completion of a legal full sequence.
REQ-009 left_cnt, right_cnt  output  8 each  completed-sequence counters, saturating.
REQ-010 error  output  1  sticky protocol-violation flag.
REQ-011 err_code  output  2  0 NONE, 1 BAD_START, 2 BAD_STEP, 3 BOTH_SIDES.

Function
REQ-012 Patterns: OFF = all six lamps 0; L1 = la; L2 = la,lb; L3 = la,lb,lc; R1/R2/R3 likewise on ra,rb,rc; every other pattern is illegal.
REQ-013 States: IDLE, L1, L2, L3, R1, R2, R3, ERR; a hold counter (4 bits) counts cycles spent in the current lit state.
REQ-014 Lamps sampled every rising edge; all outputs registered; response to a sample at edge n is visible after edge n.
REQ-015 IDLE: OFF stays IDLE; L1 -> L1; R1 -> R1; any left and right lamp lit together -> ERR code 3; any other pattern -> ERR code 1.
REQ-016 Lit state Lk/Rk: same pattern while hold counter < STEP_CYCLES stays; after exactly STEP_CYCLES cycles the next pattern (k+1, or OFF after step 3) is required; any other pattern or early/late change -> ERR code 2.
REQ-017 L3 -> OFF after STEP_CYCLES: go IDLE, pulse left_done for one cycle, left_cnt increments; R3 mirrors onto right_done/right_cnt.
REQ-018 Both-sides detection (any of la/lb/lc with any of ra/rb/rc) takes precedence over BAD_START and BAD_STEP in every state.
REQ-019 Counters saturate at 255; no wrap; cleared only by reset.
REQ-020 ERR: lamp inputs ignored, error=1, err_code held; leaves only on reset or clear.
REQ-021 clear in any state: next state IDLE, error=0, err_code=0, hold counter 0, counters unchanged, no done pulse that cycle.
REQ-022 clear coincident with a violation: clear wins, next state IDLE, no error raised.
REQ-023 left_active=1 in L1..L3 only; right_active=1 in R1..R3 only; both 0 in IDLE and ERR.

Reset
REQ-024 reset has priority over clear and all inputs; next state IDLE.
REQ-025 Reset values: left_active=0, right_active=0, left_done=0, right_done=0, left_cnt=0, right_cnt=0, error=0, err_code=0, hold counter=0.
REQ-026 reset asserted mid-sequence abandons the sequence with no done pulse and no counter change beyond zeroing.

Structure
REQ-027 Shared package taillight_pkg holds the state enum, the 2-bit error-code enum and the six-bit pattern constants OFF, L1..L3, R1..R3.
REQ-028 One combinational sub-module taillight_classify maps the six lamps to a pattern class (OFF, L1..L3, R1..R3, BOTH, ILLEGAL); the FSM consumes only the class.

Verification
REQ-029 STEP_CYCLES=1: OFF, L1, L2, L3, OFF -> left_done pulses one cycle after the final OFF sample, left_cnt=1, error=0.
REQ-030 STEP_CYCLES=2: R1,R1,R2,R2,R3,R3,OFF -> right_done once, right_cnt=1; repeat with R2 held only one cycle -> error=1, err_code=2.
REQ-031 In L2 drive la,lb,ra -> error=1, err_code=3, left_active=0; later lamp activity leaves err_code=3.
REQ-032 From IDLE drive la,lc -> err_code=1; assert clear one cycle -> error=0, IDLE, counters unchanged.
REQ-033 Run 260 legal left sequences -> left_cnt=255 and left_done still pulses each time.
REQ-034 Assert reset during R2 -> all outputs at reset values next cycle; assert clear together with a violation -> error stays 0.
